// File: rtl/frame_scheduler.sv
// Frame scheduler: steps a fetch -> vertex -> pixel pipeline through N+2
// steps per frame, generating stage start pulses, the pipeline advance
// enable, per-step fetch addresses, a frame-done pulse and a sticky irq.
module frame_scheduler #(
    parameter int MADDR_WIDTH   = 32,
    parameter int VERTEX_STRIDE = 18,
    parameter int COLOR_STRIDE  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [31:0]            triangles_count,
    input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [MADDR_WIDTH-1:0] base_addr_color,
    input  logic                   fetch_eoc,
    input  logic                   ver_eoc,
    input  logic                   pix_eoc,
    input  logic                   irq_ack,
    output logic                   fetch_start,
    output logic                   ver_start,
    output logic                   pix_start,
    output logic                   advance,
    output logic [MADDR_WIDTH-1:0] curr_addr_vertex,
    output logic [MADDR_WIDTH-1:0] curr_addr_color,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   irq,
    output logic [31:0]            step
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_STEP  = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [MADDR_WIDTH-1:0] VSTRIDE = MADDR_WIDTH'(VERTEX_STRIDE);
    localparam logic [MADDR_WIDTH-1:0] CSTRIDE = MADDR_WIDTH'(COLOR_STRIDE);

    logic [2:0]             r_state;
    logic                   r_hold;
    logic [31:0]            r_n;
    logic [31:0]            r_step;
    logic [MADDR_WIDTH-1:0] r_addr_v;
    logic [MADDR_WIDTH-1:0] r_addr_c;
    logic                   r_advance;
    logic                   r_fetch_start;
    logic                   r_ver_start;
    logic                   r_pix_start;
    logic                   r_frame_done;
    logic                   r_busy;
    logic                   r_irq;

    logic [2:0]  w_next_state;
    logic [31:0] w_next_step;
    logic        w_next_hold;
    logic [31:0] w_n;
    logic [32:0] w_n33;
    logic [32:0] w_last33;
    logic [32:0] w_step33;
    logic [32:0] w_next_step33;
    logic        w_eoc_all;
    logic        w_enter_step;
    logic        w_fetch;
    logic        w_ver;
    logic        w_pix;
    logic        w_set_done;
    logic        w_accept;

    // Next-state, next-step and the registered-output values for the coming cycle
    always_comb begin
        w_accept      = (r_state == S_IDLE) && frame_start;
        // The triangle count in force: live input while idle, snapshot otherwise.
        w_n           = (r_state == S_IDLE) ? triangles_count : r_n;
        // 33-bit compares so that N = 0xFFFFFFFF still has a final step N+1.
        w_n33         = {1'b0, w_n};
        w_last33      = w_n33 + 33'd1;
        w_step33      = {1'b0, r_step};
        w_eoc_all     = fetch_eoc && ver_eoc && pix_eoc;
        w_next_state  = r_state;
        w_next_step   = r_step;
        w_next_hold   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next_step = 32'd0;
                    if (triangles_count == 32'd0) begin
                        // Empty frame: DONE is held one extra cycle, and
                        // frame_done marks the second of those cycles.
                        w_next_state = S_DONE;
                        w_next_hold  = 1'b1;
                    end else begin
                        w_next_state = S_STEP;
                    end
                end
            end
            S_STEP: begin
                w_next_state = S_GUARD;
            end
            S_GUARD: begin
                // Stages may not have dropped eoc yet; ignore it for one cycle.
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_eoc_all) begin
                    if (w_step33 < w_last33) begin
                        w_next_state = S_STEP;
                        w_next_step  = r_step + 32'd1;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_state = r_hold ? S_DONE : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        w_next_step33 = {1'b0, w_next_step};
        w_enter_step  = (w_next_state == S_STEP);
        w_fetch       = w_enter_step && (w_next_step33 < w_n33);
        w_ver         = w_enter_step && (w_next_step33 >= 33'd1) && (w_next_step33 <= w_n33);
        w_pix         = w_enter_step && (w_next_step33 >= 33'd2);
        w_set_done    = (w_next_state == S_DONE) && !w_next_hold;
    end

    // State, snapshot, address and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_hold        <= 1'b0;
            r_n           <= '0;
            r_step        <= '0;
            r_addr_v      <= '0;
            r_addr_c      <= '0;
            r_advance     <= 1'b0;
            r_fetch_start <= 1'b0;
            r_ver_start   <= 1'b0;
            r_pix_start   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_hold        <= w_next_hold;
            r_step        <= w_next_step;
            if (w_accept) begin
                r_n <= triangles_count;
            end
            // Addresses start at the base on the first step and then advance
            // by one stride per step; they hold between steps.
            if (w_enter_step) begin
                if (r_state == S_IDLE) begin
                    r_addr_v <= base_addr_vertex;
                    r_addr_c <= base_addr_color;
                end else begin
                    r_addr_v <= r_addr_v + VSTRIDE;
                    r_addr_c <= r_addr_c + CSTRIDE;
                end
            end
            r_advance     <= w_enter_step;
            r_fetch_start <= w_fetch;
            r_ver_start   <= w_ver;
            r_pix_start   <= w_pix;
            r_frame_done  <= w_set_done;
            r_busy        <= (w_next_state != S_IDLE);
            // Setting wins over a coincident acknowledge.
            r_irq         <= w_set_done || (r_irq && !irq_ack);
        end
    end

    assign fetch_start      = r_fetch_start;
    assign ver_start        = r_ver_start;
    assign pix_start        = r_pix_start;
    assign advance          = r_advance;
    assign curr_addr_vertex = r_addr_v;
    assign curr_addr_color  = r_addr_c;
    assign frame_done       = r_frame_done;
    assign busy             = r_busy;
    assign irq              = r_irq;
    assign step             = r_step;

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter MADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter VERTEX_STRIDE, default 18, bytes of vertex data per triangle.
REQ-003 SHALL have parameter COLOR_STRIDE, default 2, bytes of color data per triangle.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 frame_start  in  1  one-cycle request to render a frame.
REQ-007 triangles_count  in  32  triangles in frame (N).
REQ-008 base_addr_vertex, base_addr_color  in  MADDR_WIDTH each  frame base addresses.
REQ-009 fetch_eoc, ver_eoc, pix_eoc  in  1 each  stage idle/complete; high when idle.
REQ-010 irq_ack  in  1  clears irq.
REQ-011 fetch_start, ver_start, pix_start  out  1 each  one-cycle stage start pulses.
REQ-012 advance  out  1  one-cycle enable for the inter-stage pipeline registers.
REQ-013 curr_addr_vertex, curr_addr_color  out  MADDR_WIDTH each  fetch addresses.
REQ-014 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-015 busy  out  1  frame in progress.
REQ-016 irq  out  1  sticky interrupt.
REQ-017 step  out  32  current step index s.

Function
REQ-018 SHALL implement states IDLE, STEP, GUARD, WAIT, DONE.
REQ-019 In IDLE, frame_start SHALL do three things: snapshot N and both base addresses, clear s to 0, and enter STEP next cycle. If N=0, it SHALL instead enter DONE.
REQ-020 A frame of N triangles SHALL take N+2 steps (s = 0..N+1) through the 3-stage fetch/vertex/pixel pipeline.
REQ-021 In STEP, the block SHALL do all of the following for exactly one cycle:
- advance=1.
- fetch_start=(s<N).
- ver_start=(1<=s<=N).
- pix_start=(2<=s<=N+1).
Next state SHALL be GUARD.
REQ-022 During STEP, curr_addr_vertex SHALL equal base_vertex+s*VERTEX_STRIDE and curr_addr_color SHALL equal base_color+s*COLOR_STRIDE. Both SHALL be held until the next STEP and wrap modulo 2^MADDR_WIDTH.
REQ-023 GUARD SHALL last exactly one cycle, ignore all eoc inputs, and go to WAIT.
REQ-024 WAIT SHALL stay until fetch_eoc, ver_eoc and pix_eoc are all high in the same cycle. It SHALL then go to STEP with s+1 if s<N+1, else to DONE.
REQ-025 DONE SHALL pulse frame_done for one cycle, set irq, and return to IDLE.
REQ-026 busy SHALL be 1 in STEP, GUARD, WAIT and DONE, and 0 in IDLE.
REQ-027 frame_start SHALL be ignored when not in IDLE.
REQ-028 irq SHALL stay set until irq_ack. If set and irq_ack occur in the same cycle, set SHALL win.
REQ-029 Changes to triangles_count or the base addresses mid-frame SHALL have no effect until the next accepted frame_start.
REQ-030 All outputs SHALL be registered. Minimum step period SHALL be 3 cycles (STEP, GUARD, WAIT).
REQ-031 N SHALL be treated as unsigned. N=0xFFFFFFFF SHALL not overflow step comparisons (use a 33-bit compare).

Reset
REQ-032 On a clk edge with reset_n=0:
- state SHALL become IDLE.
- all pulses, busy, irq, step and both addresses SHALL become 0.
- snapshots SHALL be cleared.
REQ-033 Reset mid-frame SHALL abort the frame with no frame_done and no irq.
REQ-034 The first frame_start SHALL be accepted on the cycle after reset_n returns high.

Verification
REQ-035 N=1, bases 0x1000/0x2000, eoc always 1:
- 3 STEPs: s0 fetch only; s1 ver only; s2 pix only.
- curr_addr_vertex at s0 = 0x1000.
- frame_done 10 cycles after frame_start.
- irq=1.
REQ-036 N=3, pix_eoc held low 5 cycles after each pix_start:
- exactly 5 advance pulses.
- fetch at s0-2, ver at s1-3, pix at s2-4.
- vertex addresses 0x1000, 0x1012, 0x1024.
REQ-037 N=0: frame_start -> no start pulses, no advance; frame_done 2 cycles later; irq=1.
REQ-038 frame_start repeated during WAIT -> ignored; step count and addresses unchanged; exactly one frame_done.
REQ-039 irq_ack coincident with the frame_done set cycle -> irq stays 1; irq_ack next cycle -> irq=0.
REQ-040 reset_n low for 1 cycle during WAIT at s=2 of N=4:
- all outputs 0, no frame_done.
- a new frame_start runs a full N=4 sequence from s=0.
